// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Shared defaults and register address/data types for the
//            writeback register file, scoreboard, EX and decode stages.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int DEF_NUM_REGS = 64;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CNT_W    = 2;
  localparam int REG_ADDR_W   = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard
// Brief    : Per-register pending-write counters plus the busy/stall logic
//            that keeps dependent instructions from issuing too early.
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      issue_valid_i,
  input  logic      issue_rs_en_i,
  input  logic      issue_rt_en_i,
  input  logic      issue_regwrite_i,
  input  reg_addr_t issue_rd_i,
  input  reg_addr_t rs_addr_i,
  input  reg_addr_t rt_addr_i,
  input  logic      wb_regwrite_i,
  input  reg_addr_t wb_rd_i,
  output logic      stall_o
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic w_rs_busy;
  logic w_rt_busy;
  logic w_rd_full;
  logic w_stall;
  logic w_accept;

  // Busy/stall: a source whose only outstanding write retires this cycle is
  // served by the bypass, and a full destination frees a slot on retire.
  always_comb begin
    w_rs_busy = issue_rs_en_i && (w_cnt[rs_addr_i] != '0) &&
                !((w_cnt[rs_addr_i] == c_CNT_ONE) && wb_regwrite_i && (wb_rd_i == rs_addr_i));
    w_rt_busy = issue_rt_en_i && (w_cnt[rt_addr_i] != '0) &&
                !((w_cnt[rt_addr_i] == c_CNT_ONE) && wb_regwrite_i && (wb_rd_i == rt_addr_i));
    w_rd_full = issue_regwrite_i && (w_cnt[issue_rd_i] == c_CNT_MAX) &&
                !(wb_regwrite_i && (wb_rd_i == issue_rd_i));
    w_stall   = issue_valid_i && (w_rs_busy || w_rt_busy || w_rd_full);
    w_accept  = issue_valid_i && issue_regwrite_i && !w_stall;
  end

  assign stall_o = w_stall;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign w_inc    = w_accept && (issue_rd_i == REG_ADDR_W'(r));
    assign w_dec    = wb_regwrite_i && (wb_rd_i == REG_ADDR_W'(r));
    assign w_cnt[r] = cnt_q;

    // Next count: accept and retire of the same register cancel out; a
    // retire against an idle counter is spurious and leaves it at zero.
    always_comb begin
      cnt_d = cnt_q;
      if (w_inc && !w_dec) begin
        cnt_d = cnt_q + c_CNT_ONE;
      end else if (w_dec && !w_inc && (cnt_q != '0)) begin
        cnt_d = cnt_q - c_CNT_ONE;
      end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Register file with write-first combinational read bypass and an
//            attached pending-write scoreboard generating the issue stall.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wb_regWrite,
  input  reg_addr_t         wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  reg_addr_t         rs_addr,
  input  reg_addr_t         rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic              issue_rs_en,
  input  logic              issue_rt_en,
  input  logic              issue_regWrite,
  input  reg_addr_t         issue_rd,
  output logic              stall
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Storage: every register, r0 included, is writable; cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_regWrite) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Write-first reads: a same-cycle writeback to the read address wins.
  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
    if (wb_regWrite && (wb_rd == rs_addr)) begin
      rs_data = wb_data;
    end
    if (wb_regWrite && (wb_rd == rt_addr)) begin
      rt_data = wb_data;
    end
  end

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clock            (clock),
    .reset_n          (reset_n),
    .issue_valid_i    (issue_valid),
    .issue_rs_en_i    (issue_rs_en),
    .issue_rt_en_i    (issue_rt_en),
    .issue_regwrite_i (issue_regWrite),
    .issue_rd_i       (issue_rd),
    .rs_addr_i        (rs_addr),
    .rt_addr_i        (rt_addr),
    .wb_regwrite_i    (wb_regWrite),
    .wb_rd_i          (wb_rd),
    .stall_o          (stall)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking bench for wb_regfile: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_regWrite;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  rs_addr;
  logic [5:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        issue_valid;
  logic        issue_rs_en;
  logic        issue_rt_en;
  logic        issue_regWrite;
  logic [5:0]  issue_rd;
  logic        stall;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: plain integer counts of outstanding writes and values.
  int          m_cnt [64];
  logic [31:0] m_reg [64];

  always #5 clock = ~clock;

  wb_regfile dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wb_regWrite    (wb_regWrite),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .issue_valid    (issue_valid),
    .issue_rs_en    (issue_rs_en),
    .issue_rt_en    (issue_rt_en),
    .issue_regWrite (issue_regWrite),
    .issue_rd       (issue_rd),
    .stall          (stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view of the combinational outputs.
  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (wb_regWrite && wb_rd == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_src_busy(input logic en, input logic [5:0] a);
    if (!en || m_cnt[a] == 0) return 1'b0;
    if (m_cnt[a] == 1 && wb_regWrite && wb_rd == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_stall();
    logic full;
    full = issue_regWrite && (m_cnt[issue_rd] == 3) && !(wb_regWrite && wb_rd == issue_rd);
    return issue_valid && (m_src_busy(issue_rs_en, rs_addr) ||
                           m_src_busy(issue_rt_en, rt_addr) || full);
  endfunction

  // Reset clears the model the moment it asserts.
  always @(negedge reset_n) begin
    for (int i = 0; i < 64; i++) begin
      m_cnt[i] = 0;
      m_reg[i] = '0;
    end
  end

  // Model update at each active edge outside reset.
  always @(posedge clock) begin
    if (reset_n === 1'b1) begin
      logic acc;
      acc = issue_valid && issue_regWrite && !m_stall();
      if (!(acc && wb_regWrite && issue_rd == wb_rd)) begin
        if (acc) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
        if (wb_regWrite && m_cnt[wb_rd] > 0) m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
      end
      if (wb_regWrite) m_reg[wb_rd] = wb_data;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clock) begin
    check("rs_data", rs_data, m_read(rs_addr));
    check("rt_data", rt_data, m_read(rt_addr));
    check("stall", {31'd0, stall}, {31'd0, m_stall()});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_regWrite = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; issue_rs_en = 0; issue_rt_en = 0;
    issue_regWrite = 0; issue_rd = 0; rs_addr = 0; rt_addr = 0;
  endtask

  task automatic do_issue(input logic [5:0] rd);
    issue_valid = 1; issue_regWrite = 1; issue_rd = rd;
    issue_rs_en = 0; issue_rt_en = 0;
  endtask

  initial begin
    idle();
    reset_n = 0;
    #1;
    step();
    // During reset: cleared reads, zero-counter stall.
    issue_valid = 1; issue_rs_en = 1; rs_addr = 5;
    #2 check("in_reset_rs", rs_data, 32'h0);
    check("in_reset_stall", {31'd0, stall}, 32'd0);
    step();
    reset_n = 1;
    step();

    // Read r5 after reset.
    #2 check("r5_after_reset", rs_data, 32'h0);
    check("r5_stall", {31'd0, stall}, 32'd0);
    step(); idle();

    // Same-cycle bypass then stored value.
    wb_regWrite = 1; wb_rd = 7; wb_data = 32'hDEADBEEF; rs_addr = 7;
    #2 check("bypass_r7", rs_data, 32'hDEADBEEF);
    step(); wb_regWrite = 0;
    #2 check("stored_r7", rs_data, 32'hDEADBEEF);
    step(); idle();

    // RAW stall on r3 until its writeback arrives.
    do_issue(6'd3);
    #2 check("raw_issue_acc", {31'd0, stall}, 32'd0);
    step(); idle();
    issue_valid = 1; issue_rs_en = 1; rs_addr = 3;
    #2 check("raw_stall_1", {31'd0, stall}, 32'd1);
    step();
    check("raw_stall_2", {31'd0, stall}, 32'd1);
    wb_regWrite = 1; wb_rd = 3; wb_data = 32'hA5A5_0003;
    #2 check("raw_release", {31'd0, stall}, 32'd0);
    check("raw_bypass", rs_data, 32'hA5A5_0003);
    step(); idle();

    // Saturation on r9.
    for (int k = 0; k < 3; k++) begin
      do_issue(6'd9);
      #2 check("sat_fill", {31'd0, stall}, 32'd0);
      step();
    end
    do_issue(6'd9);
    #2 check("sat_stall", {31'd0, stall}, 32'd1);
    wb_regWrite = 1; wb_rd = 9; wb_data = 32'h9;
    #1 check("sat_retire_accept", {31'd0, stall}, 32'd0);
    step(); wb_regWrite = 0;
    #2 check("sat_still_full", {31'd0, stall}, 32'd1);
    idle();
    for (int k = 0; k < 3; k++) begin
      wb_regWrite = 1; wb_rd = 9; wb_data = 32'h90 + k;
      step();
    end
    idle(); issue_valid = 1; issue_rs_en = 1; rs_addr = 9;
    #2 check("sat_drained", {31'd0, stall}, 32'd0);
    step(); idle();

    // Accept and retire of r2 together leave the count at 1.
    do_issue(6'd2);
    step();
    wb_regWrite = 1; wb_rd = 2; wb_data = 32'h22;
    #2 check("r2_acc_ret", {31'd0, stall}, 32'd0);
    step(); idle();
    issue_valid = 1; issue_rs_en = 1; rs_addr = 2;
    #2 check("r2_still_pending", {31'd0, stall}, 32'd1);
    wb_regWrite = 1; wb_rd = 2; wb_data = 32'h23;
    #1 check("r2_count_one", {31'd0, stall}, 32'd0);
    step(); idle();

    // Spurious retire of r4 writes data and leaves count at 0.
    wb_regWrite = 1; wb_rd = 4; wb_data = 32'h4444;
    step(); idle();
    issue_valid = 1; issue_rs_en = 1; rs_addr = 4;
    #2 check("r4_not_busy", {31'd0, stall}, 32'd0);
    check("r4_written", rs_data, 32'h4444);
    step(); idle();

    // Mid-operation reset with r1 pending twice.
    wb_regWrite = 1; wb_rd = 1; wb_data = 32'h1234;
    step(); idle();
    do_issue(6'd1); step();
    do_issue(6'd1); step();
    idle(); issue_valid = 1; issue_rs_en = 1; rs_addr = 1;
    #1 check("r1_pending", {31'd0, stall}, 32'd1);
    check("r1_value", rs_data, 32'h1234);
    reset_n = 0;
    #1 check("r1_reset_stall", {31'd0, stall}, 32'd0);
    check("r1_reset_data", rs_data, 32'h0);
    #1 reset_n = 1;
    step();
    check("r1_after_reset", {31'd0, stall}, 32'd0);
    idle();
    step();

    // Randomized traffic, with occasional asynchronous reset pulses.
    for (int n = 0; n < 4000; n++) begin
      issue_valid    = ($urandom_range(0, 3) != 0);
      issue_rs_en    = $urandom_range(0, 1);
      issue_rt_en    = $urandom_range(0, 1);
      issue_regWrite = $urandom_range(0, 1);
      issue_rd       = 6'($urandom_range(0, 7));
      rs_addr        = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      rt_addr        = 6'($urandom_range(0, 7));
      wb_regWrite    = ($urandom_range(0, 2) == 0);
      wb_rd          = 6'($urandom_range(0, 7));
      wb_data        = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_n = 0;
        #1 reset_n = 1;
      end
      step();
    end

    idle();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
